// File: rtl/l2_cache_wb_pkg.sv
// Shared types and parameter-derived helpers for the write-back L2 cache.
package l2_cache_wb_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_WRITEBACK = 3'd2,
        S_REFILL    = 3'd3,
        S_RESPOND   = 3'd4
    } state_t;

    // Performance counters stick here instead of wrapping.
    localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

    function automatic int calc_off_w(input int data_width, input int block_words);
        return $clog2(block_words * data_width / 8);
    endfunction

    function automatic int calc_idx_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int calc_tag_w(input int addr_width, input int data_width,
                                      input int block_words, input int num_sets);
        return addr_width - calc_idx_w(num_sets) - calc_off_w(data_width, block_words);
    endfunction

endpackage

// File: rtl/l2_cache_wb_if.sv
// L1-side request/response and memory-side request/ready bundle.
// slave = the cache, master = the L1/memory environment around it.
interface l2_cache_wb_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_WORDS = 16
);
    localparam int BLK_W = BLOCK_WORDS * DATA_WIDTH;

    logic             req_valid;
    logic             req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [BLK_W-1:0] req_wdata;
    logic             req_ready;
    logic             resp_valid;
    logic             resp_hit;
    logic [BLK_W-1:0] resp_rdata;
    logic             mem_req_valid;
    logic             mem_req_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [BLK_W-1:0] mem_wdata;
    logic [BLK_W-1:0] mem_rdata;
    logic             mem_ready;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ready,
        output req_ready, resp_valid, resp_hit, resp_rdata,
               mem_req_valid, mem_req_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ready,
        input  req_ready, resp_valid, resp_hit, resp_rdata,
               mem_req_valid, mem_req_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/l2_lru_age.sv
// Per-set true-LRU age table. Ages form a permutation 0..NUM_WAYS-1;
// the way holding the maximum age is the replacement candidate.
module l2_lru_age
    import l2_cache_wb_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4,
    localparam int IDX_W   = $clog2(NUM_SETS),
    localparam int WAY_W   = $clog2(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             touch,
    input  logic [WAY_W-1:0] touch_way,
    output logic [WAY_W-1:0] victim_way
);

    logic [NUM_SETS-1:0][NUM_WAYS-1:0][WAY_W-1:0] age;

    // Touched way becomes youngest; everything younger than it ages by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++)
                for (int w = 0; w < NUM_WAYS; w++)
                    age[s][w] <= WAY_W'(w);
        end else if (touch) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_W'(w) == touch_way)
                    age[set_idx][w] <= '0;
                else if (age[set_idx][w] < age[set_idx][touch_way])
                    age[set_idx][w] <= age[set_idx][w] + WAY_W'(1);
            end
        end
    end

    // Oldest way of the addressed set.
    always_comb begin
        victim_way = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            if (age[set_idx][w] == WAY_W'(NUM_WAYS - 1))
                victim_way = WAY_W'(w);
    end

endmodule

// File: rtl/l2_cache_wb.sv
// Write-back, write-allocate, set-associative L2 with true-LRU replacement,
// configurable lookup latency and saturating hit/miss counters.
module l2_cache_wb
    import l2_cache_wb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_SETS    = 16,
    parameter int NUM_WAYS    = 4,
    parameter int BLOCK_WORDS = 16,
    parameter int HIT_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    l2_cache_wb_if.slave bus,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int BLK_W = BLOCK_WORDS * DATA_WIDTH;
    localparam int OFF_W = calc_off_w(DATA_WIDTH, BLOCK_WORDS);
    localparam int IDX_W = calc_idx_w(NUM_SETS);
    localparam int TAG_W = calc_tag_w(ADDR_WIDTH, DATA_WIDTH, BLOCK_WORDS, NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int LAT_W = (HIT_LATENCY > 1) ? $clog2(HIT_LATENCY) : 1;

    state_t state, state_nxt;

    logic [LAT_W-1:0] lat_cnt;
    logic [TAG_W-1:0] cap_tag;
    logic [IDX_W-1:0] cap_idx;
    logic             cap_write;
    logic [BLK_W-1:0] cap_wdata;
    logic [WAY_W-1:0] victim_r;
    logic             refill_gap;
    logic             resp_hit_r;
    logic [BLK_W-1:0] rdata_r;

    logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid, dirty;
    logic [TAG_W-1:0] tag_arr  [NUM_SETS][NUM_WAYS];
    logic [BLK_W-1:0] data_arr [NUM_SETS][NUM_WAYS];

    logic [NUM_WAYS-1:0] way_hit;
    logic             hit, miss_dirty, lookup_done, mem_active, mem_done;
    logic [WAY_W-1:0] hit_way, lru_way, miss_way;
    logic             wr_en, wr_dirty, wr_from_mem, clr_dirty, touch;
    logic [WAY_W-1:0] wr_way, touch_way;

    // Block offset bits never reach the cache state.
    logic unused_off;
    assign unused_off = ^bus.req_addr[OFF_W-1:0];

    generate
        for (genvar w = 0; w < NUM_WAYS; w++) begin : g_cmp
            assign way_hit[w] = valid[cap_idx][w] && (tag_arr[cap_idx][w] == cap_tag);
        end
    endgenerate

    assign lookup_done = (state == S_LOOKUP) && (lat_cnt == '0);
    // One idle cycle separates a writeback from the following refill.
    assign mem_active  = (state == S_WRITEBACK) || ((state == S_REFILL) && !refill_gap);
    assign mem_done    = mem_active && bus.mem_ready;

    l2_lru_age #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) u_lru (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_idx    (cap_idx),
        .touch      (touch),
        .touch_way  (touch_way),
        .victim_way (lru_way)
    );

    // Hit way encode; victim prefers the lowest invalid way over the LRU way.
    always_comb begin
        hit     = |way_hit;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            if (way_hit[w]) hit_way = WAY_W'(w);
        miss_way = lru_way;
        for (int w = NUM_WAYS - 1; w >= 0; w--)
            if (!valid[cap_idx][w]) miss_way = WAY_W'(w);
        miss_dirty = valid[cap_idx][miss_way] && dirty[cap_idx][miss_way];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (bus.req_valid) state_nxt = S_LOOKUP;
            S_LOOKUP: begin
                if (lookup_done) begin
                    if (hit)             state_nxt = S_RESPOND;
                    else if (miss_dirty) state_nxt = S_WRITEBACK;
                    else if (!cap_write) state_nxt = S_REFILL;
                    else                 state_nxt = S_RESPOND;
                end
            end
            S_WRITEBACK: if (mem_done) state_nxt = cap_write ? S_RESPOND : S_REFILL;
            S_REFILL:    if (mem_done) state_nxt = S_RESPOND;
            S_RESPOND:   state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs and array update strobes decoded from the state.
    always_comb begin
        bus.req_ready     = (state == S_IDLE);
        bus.resp_valid    = (state == S_RESPOND);
        bus.resp_hit      = (state == S_RESPOND) && resp_hit_r;
        bus.resp_rdata    = rdata_r;
        bus.mem_req_valid = mem_active;
        bus.mem_req_write = (state == S_WRITEBACK);
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        if (state == S_WRITEBACK) begin
            bus.mem_addr  = {tag_arr[cap_idx][victim_r], cap_idx, {OFF_W{1'b0}}};
            bus.mem_wdata = data_arr[cap_idx][victim_r];
        end else if (mem_active) begin
            bus.mem_addr  = {cap_tag, cap_idx, {OFF_W{1'b0}}};
        end

        wr_en       = 1'b0;
        wr_way      = victim_r;
        wr_dirty    = 1'b1;
        wr_from_mem = 1'b0;
        clr_dirty   = 1'b0;
        touch       = 1'b0;
        touch_way   = victim_r;
        case (state)
            S_LOOKUP: begin
                if (lookup_done && hit) begin
                    touch     = 1'b1;
                    touch_way = hit_way;
                    wr_en     = cap_write;
                    wr_way    = hit_way;
                end else if (lookup_done && !miss_dirty && cap_write) begin
                    wr_en     = 1'b1;
                    wr_way    = miss_way;
                    touch     = 1'b1;
                    touch_way = miss_way;
                end
            end
            S_WRITEBACK: begin
                if (mem_done && cap_write) begin
                    wr_en = 1'b1;
                    touch = 1'b1;
                end else if (mem_done) begin
                    clr_dirty = 1'b1;
                end
            end
            S_REFILL: begin
                if (mem_done) begin
                    wr_en       = 1'b1;
                    wr_dirty    = 1'b0;
                    wr_from_mem = 1'b1;
                    touch       = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Request capture, lookup countdown, status bits, response data, counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt    <= '0;
            cap_tag    <= '0;
            cap_idx    <= '0;
            cap_write  <= 1'b0;
            cap_wdata  <= '0;
            victim_r   <= '0;
            refill_gap <= 1'b0;
            resp_hit_r <= 1'b0;
            rdata_r    <= '0;
            valid      <= '0;
            dirty      <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            if ((state == S_IDLE) && bus.req_valid) begin
                lat_cnt   <= LAT_W'(HIT_LATENCY - 1);
                cap_tag   <= bus.req_addr[ADDR_WIDTH-1 -: TAG_W];
                cap_idx   <= bus.req_addr[OFF_W +: IDX_W];
                cap_write <= bus.req_write;
                cap_wdata <= bus.req_wdata;
            end else if ((state == S_LOOKUP) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end

            if (lookup_done) begin
                victim_r   <= miss_way;
                resp_hit_r <= hit;
                if (hit) begin
                    if (hit_cnt != CNT_SAT) hit_cnt <= hit_cnt + 32'd1;
                    if (!cap_write) rdata_r <= data_arr[cap_idx][hit_way];
                end else if (miss_cnt != CNT_SAT) begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end

            refill_gap <= (state == S_WRITEBACK) && mem_done;

            if (wr_en) begin
                valid[cap_idx][wr_way] <= 1'b1;
                dirty[cap_idx][wr_way] <= wr_dirty;
            end
            // Line is clean once memory holds it, even before the refill lands.
            if (clr_dirty) dirty[cap_idx][victim_r] <= 1'b0;
            if (wr_en && wr_from_mem) rdata_r <= bus.mem_rdata;
        end
    end

    // Tag/data storage; contents are only meaningful behind a valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_arr[cap_idx][wr_way]  <= cap_tag;
            data_arr[cap_idx][wr_way] <= wr_from_mem ? bus.mem_rdata : cap_wdata;
        end
    end

endmodule
